// File: rtl/divider_iterative_pkg.sv
// divider_iterative_pkg: opcode and FSM state types shared by the iterative divider and its bench
package divider_iterative_pkg;
  typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} div_op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
endpackage

// File: rtl/divider_iterative.sv
// divider_iterative: multi-cycle restoring divider producing DIV/DIVU/REM/REMU results, one quotient bit per cycle
//   clk, rst           : clock, synchronous active-high reset
//   startE, div_opcode : request and operation (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   operand1, operand2 : dividend, divisor
//   result_divide, done: registered result and its one-cycle valid pulse
//   div_use            : busy/stall to the pipeline
//   DIV_EARLY_OUT_EN   : when defined, divide-by-zero and signed overflow finish in one cycle
module divider_iterative
  import divider_iterative_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       div_opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] result_divide,
  output logic             done,
  output logic             div_use
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state_q, state_d;
  div_op_e op_q, op_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, nxt;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, res_q, res_d, mag1, mag2, qv, rv;
  logic [WIDTH+1:0] sh;
  logic sgn, s1, s2, dz_in, ovf_in, ge;
  assign sgn = ~div_opcode[0];
  assign s1 = sgn & operand1[WIDTH-1];
  assign s2 = sgn & operand2[WIDTH-1];
  assign mag1 = s1 ? -operand1 : operand1;
  assign mag2 = s2 ? -operand2 : operand2;
  assign dz_in = operand2 == '0;
  assign ovf_in = sgn & (operand1 == {1'b1, {(WIDTH-1){1'b0}}}) & (&operand2);
  // The dividend magnitude sits in quo_q and is shifted out MSB-first into the partial remainder
  assign sh = {rem_q, quo_q[WIDTH-1]};
  assign ge = sh >= {2'b00, dvs_q};
  assign nxt = (WIDTH+1)'(ge ? sh - {2'b00, dvs_q} : sh);
  assign qv = {quo_q[WIDTH-2:0], ge};
  assign rv = nxt[WIDTH-1:0];
`ifdef DIV_EARLY_OUT_EN
  logic [WIDTH-1:0] special;
  // Overflow quotient equals the dividend (most negative value); zero divisor leaves the dividend as remainder
  assign special = div_opcode[1] ? (dz_in ? operand1 : '0) : (dz_in ? '1 : operand1);
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    res_d = res_q;
    unique case (state_q)
      S_IDLE: if (startE) begin
        op_d = div_op_e'(div_opcode);
        qneg_d = s1 ^ s2;
        rneg_d = s1;
        dz_d = dz_in;
        ovf_d = ovf_in;
        cnt_d = '0;
        rem_d = '0;
        quo_d = mag1;
        dvs_d = mag2;
        state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
        if (dz_in | ovf_in) begin
          state_d = S_DONE;
          res_d = special;
        end
`endif
      end
      S_CALC: begin
        rem_d = nxt;
        quo_d = qv;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          res_d = (op_q inside {OP_REM, OP_REMU})
                ? (ovf_q ? '0 : rneg_q ? -rv : rv)
                : (dz_q ? '1 : ovf_q ? {1'b1, {(WIDTH-1){1'b0}}} : qneg_q ? -qv : qv);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= OP_DIV;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      res_q <= res_d;
    end
  end
  assign result_divide = res_q;
  assign done = state_q == S_DONE;
  assign div_use = (state_q == S_IDLE && startE) || state_q == S_CALC;
endmodule
